cu_sequencer: RTL and testbench

Parametrised multi-cycle control unit for the scpu core. Fetches instruction bytes through the PC, decodes them, fetches 0–2 operand bytes and drives register-file, memory and PC strobes to execute the instruction. It replaces the fixed-latency control unit: widths, register count and memory read latency are parameters, and it adds illegal-opcode trapping, a sticky halt and optional single-stepping.

---
 rtl/cu_pkg.sv | 50 +++++
 rtl/cu_mem_rd.sv | 41 ++++
 rtl/cu_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_cu_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg -- shared definitions for the scpu control-unit sequencer.
//   * FSM state encodings (4-bit constants)
//   * opcode constants and the instruction-byte layout
//   * small decode helpers (operand count, legality)
package cu_pkg;

    // Sequencer states
    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_OPND   = 4'd3;
    localparam logic [3:0] ST_EXEC   = 4'd4;
    localparam logic [3:0] ST_MEMRD  = 4'd5;
    localparam logic [3:0] ST_WB     = 4'd6;
    localparam logic [3:0] ST_PAUSE  = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;

    // Opcodes (instruction bits [7:4])
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs
    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] rd;
        logic [1:0] rs;
    } instr_t;

    // Number of operand bytes following the instruction byte
    function automatic logic [1:0] opnd_count(input logic [3:0] op);
        case (op)
            OP_LDI:              opnd_count = 2'd1;
            OP_LD, OP_ST, OP_JMP: opnd_count = 2'd2;
            default:             opnd_count = 2'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_NOP, OP_MOV, OP_LDI, OP_LD, OP_ST, OP_JMP, OP_HLT: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_mem_rd.sv
// cu_mem_rd -- memory read sequencer shared by instruction fetch, operand
// fetch and data load.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : held high by the owner for the whole read; the read strobes
//                follow it
//   rdata      : memory read data
//   done       : high on the sample cycle (the MEM_LAT+1'th cycle of start)
//   q          : data captured on the done cycle, held until the next done
// Handshake: the owner raises start and keeps it high until it sees done;
// done lasts one cycle and the counter rearms, so a back-to-back read simply
// keeps start high.
module cu_mem_rd #(
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [DATA_W-1:0] q
);

    localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt;

    assign done = start && (cnt == CW'(MEM_LAT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= '0;
        end else begin
            if (!start || done) cnt <= '0;
            else                cnt <= cnt + 1'b1;
            if (done)           q   <= rdata;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer -- multi-cycle control unit for the scpu core.
// Fetches an instruction byte through the PC, decodes it, fetches 0-2 operand
// bytes and drives register-file, memory and PC strobes to execute it.
// Optional feature: define CU_STEP_EN to add a PAUSE state after every
// instruction, left on a cycle where step=1.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   step                  single-step advance (CU_STEP_EN builds only)
//   data_bus_in/out       memory read / write data
//   addr_bus              memory address
//   mem_ce/r/w/oe/rst     memory strobes
//   pc_q, pc_wdata        current PC, jump target
//   pc_w/r/inc/rst        PC strobes
//   regs_raddr/waddr      register addresses
//   regs_rdata/wdata/we   register read data (combinational), write port
//   halted, illegal       sticky status
// Every output is forced to 0 while rst_n is low, so an instruction that is
// interrupted by reset issues no further writes.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int NREGS   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step,
    input  logic [DATA_W-1:0]        data_bus_in,
    output logic [DATA_W-1:0]        data_bus_out,
    output logic [ADDR_W-1:0]        addr_bus,
    output logic                     mem_ce,
    output logic                     mem_r,
    output logic                     mem_w,
    output logic                     mem_oe,
    output logic                     mem_rst,
    input  logic [ADDR_W-1:0]        pc_q,
    output logic [ADDR_W-1:0]        pc_wdata,
    output logic                     pc_w,
    output logic                     pc_r,
    output logic                     pc_inc,
    output logic                     pc_rst,
    output logic [$clog2(NREGS)-1:0] regs_raddr,
    output logic [$clog2(NREGS)-1:0] regs_waddr,
    input  logic [DATA_W-1:0]        regs_rdata,
    output logic [DATA_W-1:0]        regs_wdata,
    output logic                     regs_we,
    output logic                     halted,
    output logic                     illegal
);

    localparam int RW = $clog2(NREGS);

`ifdef CU_STEP_EN
    localparam logic [3:0] ST_END = ST_PAUSE;
`else
    localparam logic [3:0] ST_END = ST_FETCH;
`endif

    logic [3:0]        state, state_nxt;
    instr_t            ir;
    instr_t            dec;
    logic [DATA_W-1:0] opnd_hi, opnd_lo;
    logic [1:0]        opnd_left;
    logic              illegal_q;
    logic [RW-1:0]     rd_a, rs_a;
    logic [ADDR_W-1:0] opnd_addr;

    logic              rd_start, rd_done;
    logic [DATA_W-1:0] rd_q;

    logic unused_step;
    assign unused_step = step;

    // The freshly fetched byte is decoded straight from the read capture
    // register; ir keeps it for the remaining states.
    assign dec       = instr_t'(rd_q[7:0]);
    assign rd_a      = RW'(ir.rd);
    assign rs_a      = RW'(ir.rs);
    // {hi,lo} truncated or zero-extended to the address width
    assign opnd_addr = ADDR_W'({opnd_hi, opnd_lo});

    assign rd_start = rst_n && (state == ST_FETCH || state == ST_OPND || state == ST_MEMRD);

    cu_mem_rd #(
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) u_mem_rd (
        .clk  (clk),
        .rst_n(rst_n),
        .start(rd_start),
        .rdata(data_bus_in),
        .done (rd_done),
        .q    (rd_q)
    );

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_FETCH;
            ST_FETCH: if (rd_done) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (dec.opcode)
                    OP_NOP:                       state_nxt = ST_END;
                    OP_MOV:                       state_nxt = ST_EXEC;
                    OP_LDI, OP_LD, OP_ST, OP_JMP: state_nxt = ST_OPND;
                    default:                      state_nxt = ST_HALT;
                endcase
            end
            // LD goes from its last operand straight to the data read.
            ST_OPND:
                if (rd_done && opnd_left == 2'd1)
                    state_nxt = (ir.opcode == OP_LD) ? ST_MEMRD : ST_EXEC;
            ST_EXEC:  state_nxt = ST_END;
            ST_MEMRD: if (rd_done) state_nxt = ST_WB;
            ST_WB:    state_nxt = ST_END;
`ifdef CU_STEP_EN
            ST_PAUSE: if (step) state_nxt = ST_FETCH;
`endif
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RST;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RST;
            ir        <= '0;
            opnd_hi   <= '0;
            opnd_lo   <= '0;
            opnd_left <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_DECODE: begin
                    ir        <= dec;
                    opnd_left <= opnd_count(dec.opcode);
                    opnd_hi   <= '0;
                    opnd_lo   <= '0;
                    if (!op_legal(dec.opcode)) illegal_q <= 1'b1;
                end
                // Operand bytes shift in: hi arrives first, lo second; a
                // single LDI immediate lands in opnd_lo.
                ST_OPND: begin
                    if (rd_done) begin
                        opnd_hi   <= opnd_lo;
                        opnd_lo   <= data_bus_in;
                        opnd_left <= opnd_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        data_bus_out = '0;
        addr_bus     = '0;
        mem_ce       = 1'b0;
        mem_r        = 1'b0;
        mem_w        = 1'b0;
        mem_oe       = 1'b0;
        mem_rst      = 1'b0;
        pc_wdata     = '0;
        pc_w         = 1'b0;
        pc_r         = 1'b0;
        pc_inc       = 1'b0;
        pc_rst       = 1'b0;
        regs_raddr   = '0;
        regs_waddr   = '0;
        regs_wdata   = '0;
        regs_we      = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        if (rst_n) begin
            halted  = (state == ST_HALT);
            illegal = illegal_q;
            case (state)
                ST_RST: begin
                    pc_rst  = 1'b1;
                    mem_rst = 1'b1;
                end
                ST_FETCH, ST_OPND: begin
                    mem_ce   = 1'b1;
                    mem_r    = 1'b1;
                    mem_oe   = 1'b1;
                    addr_bus = pc_q;
                    pc_r     = 1'b1;
                    pc_inc   = rd_done;
                end
                ST_MEMRD: begin
                    mem_ce   = 1'b1;
                    mem_r    = 1'b1;
                    mem_oe   = 1'b1;
                    addr_bus = opnd_addr;
                end
                ST_EXEC: begin
                    case (ir.opcode)
                        OP_MOV: begin
                            regs_raddr = rs_a;
                            regs_waddr = rd_a;
                            regs_wdata = regs_rdata;
                            regs_we    = 1'b1;
                        end
                        OP_LDI: begin
                            regs_waddr = rd_a;
                            regs_wdata = opnd_lo;
                            regs_we    = 1'b1;
                        end
                        OP_ST: begin
                            regs_raddr   = rd_a;
                            addr_bus     = opnd_addr;
                            data_bus_out = regs_rdata;
                            mem_ce       = 1'b1;
                            mem_w        = 1'b1;
                        end
                        OP_JMP: begin
                            pc_wdata = opnd_addr;
                            pc_w     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_WB: begin
                    regs_waddr = rd_a;
                    regs_wdata = rd_q;
                    regs_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer -- directed bench for cu_sequencer with a behavioural
// memory, register file and PC around the sequencer.
// Cycle numbering: cycle 0 is the first cycle after reset release (RST),
// cycle 1 the first FETCH cycle. Outputs are sampled 1 time unit after the
// falling edge.
module tb_cu_sequencer;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int NREGS   = 4;
    localparam int MEM_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic step  = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] data_bus_in, data_bus_out, regs_rdata, regs_wdata;
    logic [ADDR_W-1:0] addr_bus, pc_wdata;
    logic [ADDR_W-1:0] pc_q;
    logic              mem_ce, mem_r, mem_w, mem_oe, mem_rst;
    logic              pc_w, pc_r, pc_inc, pc_rst;
    logic [1:0]        regs_raddr, regs_waddr;
    logic              regs_we, halted, illegal;

    cu_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step),
        .data_bus_in (data_bus_in),
        .data_bus_out(data_bus_out),
        .addr_bus    (addr_bus),
        .mem_ce      (mem_ce),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .mem_oe      (mem_oe),
        .mem_rst     (mem_rst),
        .pc_q        (pc_q),
        .pc_wdata    (pc_wdata),
        .pc_w        (pc_w),
        .pc_r        (pc_r),
        .pc_inc      (pc_inc),
        .pc_rst      (pc_rst),
        .regs_raddr  (regs_raddr),
        .regs_waddr  (regs_waddr),
        .regs_rdata  (regs_rdata),
        .regs_wdata  (regs_wdata),
        .regs_we     (regs_we),
        .halted      (halted),
        .illegal     (illegal)
    );

    // ---------------- environment models ----------------
    logic [7:0] mem  [0:65535];
    logic [7:0] regs [0:3];

    assign data_bus_in = mem[addr_bus];
    assign regs_rdata  = regs[regs_raddr];

    always @(posedge clk) begin
        if (pc_rst)      pc_q <= '0;
        else if (pc_w)   pc_q <= pc_wdata;
        else if (pc_inc) pc_q <= pc_q + 16'd1;
        if (regs_we)         regs[regs_waddr] <= regs_wdata;
        if (mem_ce && mem_w) mem[addr_bus]    <= data_bus_out;
    end

    logic [63:0] outs;
    logic [9:0]  strobes;
    assign outs = {data_bus_out, addr_bus, mem_ce, mem_r, mem_w, mem_oe, mem_rst,
                   pc_wdata, pc_w, pc_r, pc_inc, pc_rst, regs_raddr, regs_waddr,
                   regs_wdata, regs_we, halted, illegal};
    assign strobes = {mem_ce, mem_r, mem_w, mem_oe, mem_rst, pc_w, pc_r, pc_inc, pc_rst, regs_we};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];   // expected register write data, in order

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wdata(input string tag);
        logic [DATA_W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected <empty queue>", tag, regs_wdata);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(regs_wdata), 64'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) mem[i] = 8'hF0;
    endtask

    // Holds reset two cycles, checks the quiet outputs, releases and leaves
    // the bench sampling cycle 0 (RST).
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        check({tag, "_reset_quiet"}, outs, 64'd0);
        rst_n = 1'b1;
        #1;
        check({tag, "_release"}, {61'd0, pc_rst, mem_rst, mem_r}, 64'b110);
    endtask

    // ---------------- directed sequence ----------------
    int inc_cnt, we_cnt, strobe_cnt, w_cnt;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hF0;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;

        // NOP then HLT: 3-cycle NOP, halt without illegal
        clear_prog();
        mem[0] = 8'h00;
        do_reset("nop");
        cyc(1);
        check("nop_fetch1", {45'd0, addr_bus, mem_ce, mem_r, mem_oe, pc_r, pc_rst, mem_w, pc_inc, regs_we},
              {45'd0, 16'h0000, 8'b11110000});
        cyc(1);
        check("nop_fetch_inc", {62'd0, pc_inc, mem_r}, 64'b11);
        cyc(1);
        check("nop_decode_quiet", 64'(strobes), 64'd0);
        cyc(1);
        check("nop_next_fetch", {47'd0, addr_bus, mem_r}, {47'd0, 16'h0001, 1'b1});
        cyc(4);
        check("hlt_status", {62'd0, halted, illegal}, 64'b10);

        // LDI r0,0x5A
        clear_prog();
        mem[0] = 8'h20;
        mem[1] = 8'h5A;
        exp_q.push_back(8'h5A);
        do_reset("ldi");
        inc_cnt = 0;
        we_cnt  = 0;
        for (int c = 1; c <= 5; c++) begin
            cyc(1);
            inc_cnt += int'(pc_inc);
            we_cnt  += int'(regs_we);
        end
        check("ldi_no_early_we", 64'(we_cnt), 64'd0);
        cyc(1);
        inc_cnt += int'(pc_inc);
        check("ldi_we_c6", {61'd0, regs_we, regs_waddr}, {61'd0, 1'b1, 2'd0});
        check_wdata("ldi_wdata_c6");
        check("ldi_pc_inc_count", 64'(inc_cnt), 64'd2);
        cyc(1);
        check("ldi_r0", 64'(regs[0]), 64'h5A);

        // LD r0,[0x00FF] then MOV r1,r0
        clear_prog();
        mem[0] = 8'h90;
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        mem[3] = 8'h14;
        mem[16'h00FF] = 8'h3C;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        do_reset("ld");
        cyc(8);
        check("ld_memrd_addr", {46'd0, addr_bus, mem_r, pc_r}, {46'd0, 16'h00FF, 2'b10});
        cyc(1);
        check("ld_no_we_c9", 64'(regs_we), 64'd0);
        cyc(1);
        check("ld_wb_c10", {61'd0, regs_we, regs_waddr}, {61'd0, 1'b1, 2'd0});
        check_wdata("ld_wdata_c10");
        cyc(4);
        check("mov_exec", {59'd0, regs_we, regs_raddr, regs_waddr}, {59'd0, 1'b1, 2'd0, 2'd1});
        check_wdata("mov_wdata");

        // JMP 0x1234 landing on an illegal opcode
        clear_prog();
        mem[0] = 8'hC0;
        mem[1] = 8'h12;
        mem[2] = 8'h34;
        mem[16'h1234] = 8'h50;
        do_reset("jmp");
        cyc(7);
        check("jmp_no_early_pc_w", 64'(pc_w), 64'd0);
        cyc(1);
        check("jmp_pc_w_c8", {47'd0, pc_w, pc_wdata}, {47'd0, 1'b1, 16'h1234});
        cyc(1);
        check("jmp_target_fetch", {47'd0, addr_bus, mem_r}, {47'd0, 16'h1234, 1'b1});
        cyc(3);
        check("illegal_status", {62'd0, illegal, halted}, 64'b11);
        step = 1'b1;
        strobe_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            if (strobes != 10'd0) strobe_cnt++;
        end
        step = 1'b0;
        check("halt_strobes_quiet", 64'(strobe_cnt), 64'd0);
        check("halt_sticky", {62'd0, illegal, halted}, 64'b11);

        // ST r1,[0x0080] interrupted by reset during OPND, then run in full
        clear_prog();
        mem[0] = 8'hA4;
        mem[1] = 8'h00;
        mem[2] = 8'h80;
        mem[16'h0080] = 8'hF0;
        regs[1] = 8'h77;
        do_reset("st");
        cyc(5);
        check("st_in_opnd", {62'd0, mem_r, pc_r}, 64'b11);
        rst_n = 1'b0;
        #1;
        check("st_abort_quiet", outs, 64'd0);
        w_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            w_cnt += int'(mem_w);
        end
        check("st_abort_no_mem_w", 64'(w_cnt), 64'd0);
        check("st_abort_mem_kept", 64'(mem[16'h0080]), 64'hF0);
        rst_n = 1'b1;
        #1;
        check("st_resume_rst", {62'd0, pc_rst, mem_rst}, 64'b11);
        cyc(8);
        check("st_exec_c8", {30'd0, mem_ce, mem_w, mem_r, addr_bus, data_bus_out, regs_raddr},
              {30'd0, 3'b110, 16'h0080, 8'h77, 2'd1});
        cyc(1);
        check("st_mem_written", 64'(mem[16'h0080]), 64'h77);

`ifdef CU_STEP_EN
        // Two NOPs: PAUSE holds until step
        clear_prog();
        mem[0] = 8'h00;
        mem[1] = 8'h00;
        do_reset("step");
        cyc(4);
        check("step_pause_quiet", 64'(strobes), 64'd0);
        cyc(3);
        check("step_still_paused", 64'(mem_r), 64'd0);
        step = 1'b1;
        #1;
        cyc(1);
        step = 1'b0;
        check("step_second_fetch", {47'd0, addr_bus, mem_r}, {47'd0, 16'h0001, 1'b1});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
